// File: rtl/life_pkg.sv
// Shared types and rule masks for the Game of Life generation engine.
package life_pkg;

   typedef enum logic [2:0] {
      IDLE,
      LOAD,
      RD,
      WR,
      DONE
   } state_t;

   // Bit n set means a neighbour count of n gives a live cell (B3/S23).
   localparam logic [8:0] BIRTH_MASK   = 9'b000001000;
   localparam logic [8:0] SURVIVE_MASK = 9'b000001100;

endpackage

// File: rtl/life_row_next.sv
// Next-generation value of one board row from the rows above, at and below it,
// plus the live-cell count of the resulting row.
module life_row_next
   import life_pkg::*;
#(
   parameter int COLS   = 20,
   parameter int WRAP   = 0,
   parameter int RPOP_W = $clog2(COLS + 1)
) (
   input  logic [COLS-1:0]   top_row,
   input  logic [COLS-1:0]   mid_row,
   input  logic [COLS-1:0]   bot_row,
   output logic [COLS-1:0]   next_row,
   output logic [RPOP_W-1:0] next_pop
);

   localparam logic WRAP_EN = (WRAP != 0);

   // Bit c of the result holds the cell at column c-1 (or c+1); the edge
   // column is either the opposite edge or dead.
   function automatic logic [COLS-1:0] from_left(input logic [COLS-1:0] v);
      return {v[COLS-2:0], WRAP_EN & v[COLS-1]};
   endfunction

   function automatic logic [COLS-1:0] from_right(input logic [COLS-1:0] v);
      return {WRAP_EN & v[0], v[COLS-1:1]};
   endfunction

   logic [COLS-1:0] top_l, top_r, mid_l, mid_r, bot_l, bot_r;

   assign top_l = from_left(top_row);
   assign top_r = from_right(top_row);
   assign mid_l = from_left(mid_row);
   assign mid_r = from_right(mid_row);
   assign bot_l = from_left(bot_row);
   assign bot_r = from_right(bot_row);

   for (genvar c = 0; c < COLS; c++) begin : g_col
      logic [3:0] cnt;
      assign cnt = 4'(top_l[c]) + 4'(top_row[c]) + 4'(top_r[c])
                 + 4'(mid_l[c]) + 4'(mid_r[c])
                 + 4'(bot_l[c]) + 4'(bot_row[c]) + 4'(bot_r[c]);
      assign next_row[c] = mid_row[c] ? SURVIVE_MASK[cnt] : BIRTH_MASK[cnt];
   end

   always_comb begin
      next_pop = '0;
      for (int c = 0; c < COLS; c++) begin
         next_pop = next_pop + RPOP_W'(next_row[c]);
      end
   end

endmodule

// File: rtl/life_engine_p.sv
// Game of Life generation engine: in-place read-compute-write sweep of a
// row-wide cell RAM through a three-row window, with auto-step timer.
//
// state | meaning
// IDLE  | waiting for next_i or the run timer
// LOAD  | 4 cycles priming top/mid/bot/row0 window registers
// RD    | issue read of row r+2 for the window refill
// WR    | write next generation of row r, shift window
// DONE  | publish population and generation count
module life_engine_p
   import life_pkg::*;
#(
   parameter int ROWS     = 16,
   parameter int COLS     = 20,
   parameter int ADDR_W   = 4,
   parameter int WRAP     = 0,
   parameter int PERIOD_W = 26,
   parameter int GEN_W    = 16,
   parameter int POP_W    = $clog2(ROWS * COLS + 1)
) (
   input  logic                clk_50MHz_i,
   input  logic                rst_sync_ha_i,
   input  logic                next_i,
   input  logic                run_i,
   input  logic [PERIOD_W-1:0] period_i,
   input  logic [COLS-1:0]     ram_rd_data_i,
   output logic [ADDR_W-1:0]   ram_addr_o,
   output logic [COLS-1:0]     ram_wr_data_o,
   output logic                ram_we_o,
   output logic                busy_o,
   output logic                done_o,
   output logic [GEN_W-1:0]    gen_count_o,
   output logic [POP_W-1:0]    population_o
);

   localparam int   RPOP_W  = $clog2(COLS + 1);
   localparam logic WRAP_EN = (WRAP != 0);

   state_t              state_q, state_d;
   logic [1:0]          load_cnt_q;
   logic [ADDR_W-1:0]   row_q;
   logic [COLS-1:0]     top_q, mid_q, bot_q, row0_q;
   logic [PERIOD_W-1:0] timer_q;
   logic [POP_W-1:0]    acc_q;
   logic [POP_W-1:0]    population_q;
   logic [GEN_W-1:0]    gen_count_q;

   logic [COLS-1:0]     next_row;
   logic [RPOP_W-1:0]   next_pop;
   logic [ADDR_W:0]     row_ahead;
   logic                ahead_in;
   logic                ahead_wrap;
   logic                last_row;
   logic                timer_fire;
   logic                start;

   life_row_next #(
      .COLS   (COLS),
      .WRAP   (WRAP),
      .RPOP_W (RPOP_W)
   ) u_row_next (
      .top_row  (top_q),
      .mid_row  (mid_q),
      .bot_row  (bot_q),
      .next_row (next_row),
      .next_pop (next_pop)
   );

   assign row_ahead  = {1'b0, row_q} + (ADDR_W+1)'(2);
   assign ahead_in   = row_ahead < (ADDR_W+1)'(ROWS);
   assign ahead_wrap = row_ahead == (ADDR_W+1)'(ROWS);
   assign last_row   = row_q == ADDR_W'(ROWS - 1);
   assign timer_fire = run_i && (timer_q >= period_i);
   assign start      = (state_q == IDLE) && (next_i || timer_fire);

   always_ff @(posedge clk_50MHz_i) begin
      if (rst_sync_ha_i) begin
         state_q <= IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE:    if (start) state_d = LOAD;
         LOAD:    if (load_cnt_q == 2'd3) state_d = RD;
         RD:      state_d = WR;
         WR:      state_d = last_row ? DONE : RD;
         DONE:    state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_comb begin
      ram_addr_o    = '0;
      ram_wr_data_o = '0;
      ram_we_o      = 1'b0;
      busy_o        = (state_q != IDLE);
      done_o        = (state_q == DONE);
      case (state_q)
         LOAD: begin
            case (load_cnt_q)
               2'd0:    ram_addr_o = ADDR_W'(ROWS - 1);
               2'd2:    ram_addr_o = ADDR_W'(1);
               default: ram_addr_o = '0;
            endcase
         end
         RD: begin
            if (ahead_in) ram_addr_o = row_ahead[ADDR_W-1:0];
         end
         WR: begin
            ram_addr_o    = row_q;
            ram_we_o      = 1'b1;
            ram_wr_data_o = next_row;
         end
         default: ;
      endcase
   end

   always_ff @(posedge clk_50MHz_i) begin
      if (rst_sync_ha_i) begin
         load_cnt_q   <= '0;
         row_q        <= '0;
         top_q        <= '0;
         mid_q        <= '0;
         bot_q        <= '0;
         row0_q       <= '0;
         timer_q      <= '0;
         acc_q        <= '0;
         population_q <= '0;
         gen_count_q  <= '0;
      end else begin
         if (!run_i || start) begin
            timer_q <= '0;
         end else if (state_q == IDLE) begin
            timer_q <= timer_q + PERIOD_W'(1);
         end

         case (state_q)
            IDLE: begin
               load_cnt_q <= '0;
               row_q      <= '0;
            end
            LOAD: begin
               load_cnt_q <= load_cnt_q + 2'd1;
               // Read data lags the address by one cycle.
               case (load_cnt_q)
                  2'd1: top_q <= WRAP_EN ? ram_rd_data_i : '0;
                  2'd2: begin
                     mid_q  <= ram_rd_data_i;
                     row0_q <= ram_rd_data_i;
                  end
                  2'd3: bot_q <= ram_rd_data_i;
                  default: ;
               endcase
            end
            WR: begin
               top_q <= mid_q;
               mid_q <= bot_q;
               if (ahead_in) begin
                  bot_q <= ram_rd_data_i;
               end else if (WRAP_EN && ahead_wrap) begin
                  bot_q <= row0_q;
               end else begin
                  bot_q <= '0;
               end
               row_q <= row_q + ADDR_W'(1);
               // Publish on the way into DONE so the outputs are valid
               // in the same cycle as the done pulse.
               if (last_row) begin
                  population_q <= acc_q + POP_W'(next_pop);
                  gen_count_q  <= gen_count_q + GEN_W'(1);
                  acc_q        <= '0;
               end else begin
                  acc_q <= acc_q + POP_W'(next_pop);
               end
            end
            default: ;
         endcase
      end
   end

   assign gen_count_o  = gen_count_q;
   assign population_o = population_q;

endmodule

// File: tb/tb_life_engine_p.sv
// Scoreboard bench for life_engine_p: one instance per edge mode, each with
// its own RAM model, checked against a cell-by-cell Game of Life model.
`timescale 1ns/1ps
module tb_life_engine_p;

   localparam int ROWS     = 16;
   localparam int COLS     = 20;
   localparam int ADDR_W   = 4;
   localparam int PERIOD_W = 26;
   localparam int GEN_W    = 16;
   localparam int POP_W    = $clog2(ROWS * COLS + 1);
   localparam int SWEEP    = 4 + 2 * ROWS + 1;

   typedef logic [ROWS-1:0][COLS-1:0] board_t;
   typedef struct {
      int     inst;
      int     gen;
      int     pop;
      board_t board;
      int     start;
      bit     spaced;
   } exp_t;

   logic                clk = 1'b0;
   logic                rst;
   logic [1:0]          next_r;
   logic [1:0]          run_r;
   logic [PERIOD_W-1:0] period;
   logic [COLS-1:0]     rd_data [2];
   logic [COLS-1:0]     wr_data [2];
   logic [ADDR_W-1:0]   addr    [2];
   logic                we      [2];
   logic                busy    [2];
   logic                done    [2];
   logic [GEN_W-1:0]    gen     [2];
   logic [POP_W-1:0]    pop     [2];

   logic [COLS-1:0]     ram [2][ROWS];
   logic [1:0]          pre_we;
   logic [ADDR_W-1:0]   pre_addr;
   logic [COLS-1:0]     pre_data;

   int     errors = 0;
   int     checks = 0;
   int     cyc = 0;
   int     widx = 0;
   int     last_done = -1000;
   logic   we_prev [2];
   exp_t   exp_q[$];
   board_t mb [2];
   int     gen_m [2];

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   for (genvar k = 0; k < 2; k++) begin : g_dut
      life_engine_p #(
         .ROWS(ROWS), .COLS(COLS), .ADDR_W(ADDR_W), .WRAP(k),
         .PERIOD_W(PERIOD_W), .GEN_W(GEN_W), .POP_W(POP_W)
      ) u_dut (
         .clk_50MHz_i   (clk),
         .rst_sync_ha_i (rst),
         .next_i        (next_r[k]),
         .run_i         (run_r[k]),
         .period_i      (period),
         .ram_rd_data_i (rd_data[k]),
         .ram_addr_o    (addr[k]),
         .ram_wr_data_o (wr_data[k]),
         .ram_we_o      (we[k]),
         .busy_o        (busy[k]),
         .done_o        (done[k]),
         .gen_count_o   (gen[k]),
         .population_o  (pop[k])
      );
   end

   // Row-wide RAM with registered read; the preset port wins over the engine.
   always @(posedge clk) begin
      for (int k = 0; k < 2; k++) begin
         if (pre_we[k]) ram[k][pre_addr] <= pre_data;
         else if (we[k]) ram[k][addr[k]] <= wr_data[k];
         rd_data[k] <= ram[k][addr[k]];
      end
   end

   function automatic board_t life_step(board_t b, bit wrap);
      board_t n;
      int nb, rr, cc;
      for (int r = 0; r < ROWS; r++) begin
         for (int c = 0; c < COLS; c++) begin
            nb = 0;
            for (int dr = -1; dr <= 1; dr++) begin
               for (int dc = -1; dc <= 1; dc++) begin
                  if (dr != 0 || dc != 0) begin
                     rr = r + dr;
                     cc = c + dc;
                     if (wrap) begin
                        rr = (rr + ROWS) % ROWS;
                        cc = (cc + COLS) % COLS;
                        nb += int'(b[rr][cc]);
                     end else if (rr >= 0 && rr < ROWS && cc >= 0 && cc < COLS) begin
                        nb += int'(b[rr][cc]);
                     end
                  end
               end
            end
            n[r][c] = b[r][c] ? (nb == 2 || nb == 3) : (nb == 3);
         end
      end
      return n;
   endfunction

   function automatic int popc(board_t b);
      int n = 0;
      for (int r = 0; r < ROWS; r++)
         for (int c = 0; c < COLS; c++) n += int'(b[r][c]);
      return n;
   endfunction

   function automatic board_t ram_board(int k);
      board_t b;
      for (int r = 0; r < ROWS; r++) b[r] = ram[k][r];
      return b;
   endfunction

   task automatic chk(string name, logic [63:0] act, logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   task automatic chk_board(string name, board_t act, board_t exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   // Monitor: write ordering/timing and the scoreboard pop on done.
   always @(negedge clk) begin
      exp_t e;
      for (int k = 0; k < 2; k++) begin
         if (we[k]) begin
            if (exp_q.size() == 0 || exp_q[0].inst != k) begin
               chk($sformatf("stray_write%0d", k), 64'(we[k]), 64'd0);
            end else begin
               chk($sformatf("wr_addr%0d", k), 64'(addr[k]), 64'(widx));
               if (exp_q[0].start >= 0)
                  chk($sformatf("wr_cycle%0d", k), 64'(cyc), 64'(exp_q[0].start + 6 + 2 * widx));
               widx++;
            end
            chk($sformatf("we_gap%0d", k), 64'(we_prev[k]), 64'd0);
         end
         we_prev[k] = we[k];
         if (done[k]) begin
            if (exp_q.size() == 0) begin
               chk($sformatf("unexpected_done%0d", k), 64'(done[k]), 64'd0);
            end else begin
               e = exp_q.pop_front();
               chk("done_inst", 64'(k), 64'(e.inst));
               chk("gen_count", 64'(gen[k]), 64'(e.gen));
               chk("population", 64'(pop[k]), 64'(e.pop));
               chk_board("board", ram_board(k), e.board);
               if (e.start >= 0) chk("done_latency", 64'(cyc), 64'(e.start + SWEEP));
               if (e.spaced) chk("run_spacing", 64'(cyc - last_done), 64'd48);
            end
            last_done = cyc;
            widx = 0;
         end
      end
   end

   task automatic load_board(int k, board_t b);
      for (int r = 0; r < ROWS; r++) begin
         @(negedge clk);
         pre_we[k] = 1'b1;
         pre_addr  = ADDR_W'(r);
         pre_data  = b[r];
      end
      @(negedge clk);
      pre_we = '0;
      mb[k] = b;
   endtask

   task automatic step(int k, output int start_cyc);
      exp_t   e;
      board_t n;
      n = life_step(mb[k], k == 1);
      gen_m[k]++;
      @(negedge clk);
      e.inst = k; e.gen = gen_m[k]; e.pop = popc(n); e.board = n;
      e.start = cyc; e.spaced = 1'b0;
      exp_q.push_back(e);
      start_cyc = cyc;
      mb[k] = n;
      next_r[k] = 1'b1;
      @(negedge clk);
      next_r[k] = 1'b0;
   endtask

   task automatic drain();
      for (int t = 0; t < 400 && exp_q.size() != 0; t++) @(negedge clk);
      if (exp_q.size() != 0) begin
         checks++;
         errors++;
         $display("FAIL drain_timeout: %0d generations still outstanding", exp_q.size());
         exp_q.delete();
      end
   endtask

   task automatic step_wait(int k);
      int s;
      step(k, s);
      drain();
   endtask

   task automatic reset_dut();
      @(negedge clk);
      rst = 1'b1;
      repeat (2) @(negedge clk);
      rst = 1'b0;
      gen_m[0] = 0;
      gen_m[1] = 0;
      exp_q.delete();
      widx = 0;
   endtask

   function automatic board_t rand_board();
      board_t b;
      for (int r = 0; r < ROWS; r++) b[r] = COLS'($urandom & $urandom);
      return b;
   endfunction

   initial begin
      #3000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      board_t b, b1, b0, n;
      int s;
      rst = 1'b1; next_r = '0; run_r = '0; period = '0;
      pre_we = '0; pre_addr = '0; pre_data = '0;
      we_prev[0] = 1'b0; we_prev[1] = 1'b0;
      gen_m[0] = 0; gen_m[1] = 0;
      repeat (3) @(negedge clk);
      for (int k = 0; k < 2; k++) begin
         chk("rst_ctrl", {61'd0, busy[k], done[k], we[k]}, 64'd0);
         chk("rst_ram_bus", {24'd0, addr[k], wr_data[k]}, 64'd0);
         chk("rst_gen", 64'(gen[k]), 64'd0);
         chk("rst_pop", 64'(pop[k]), 64'd0);
      end
      rst = 1'b0;

      // Blinker, dead border
      b = '0; b[7][10:8] = 3'b111;
      b1 = '0; b1[6][9] = 1'b1; b1[7][9] = 1'b1; b1[8][9] = 1'b1;
      load_board(0, b);
      step_wait(0);
      chk_board("blinker_gen1", ram_board(0), b1);
      chk("blinker_pop", 64'(pop[0]), 64'd3);
      chk("blinker_gen", 64'(gen[0]), 64'd1);
      step_wait(0);
      chk_board("blinker_restore", ram_board(0), b);

      // Block still life
      b = '0; b[0][1:0] = 2'b11; b[1][1:0] = 2'b11;
      load_board(0, b);
      step_wait(0);
      chk_board("block_still", ram_board(0), b);
      chk("block_pop", 64'(pop[0]), 64'd4);

      // Vertical blinker on column 0, both edge modes
      b = '0; b[0][0] = 1'b1; b[1][0] = 1'b1; b[2][0] = 1'b1;
      for (int k = 0; k < 2; k++) begin
         load_board(k, b);
         step_wait(k);
      end
      chk("edge_dead_row1", 64'(ram[0][1]), 64'h00003);
      chk("edge_dead_pop", 64'(pop[0]), 64'd2);
      chk("edge_wrap_row1", 64'(ram[1][1]), 64'h80003);
      chk("edge_wrap_pop", 64'(pop[1]), 64'd3);

      // Random boards
      for (int k = 0; k < 2; k++) begin
         for (int i = 0; i < 3; i++) begin
            load_board(k, rand_board());
            step_wait(k);
            step_wait(k);
         end
      end

      // Glider on the torus for 80 generations from a fresh counter
      reset_dut();
      chk("glider_gen_reset", 64'(gen[1]), 64'd0);
      b = '0; b[1][2] = 1'b1; b[2][3] = 1'b1; b[3][3:1] = 3'b111;
      load_board(1, b);
      for (int i = 0; i < 80; i++) step_wait(1);
      chk("glider_gen80", 64'(gen[1]), 64'd80);

      // Auto-step: period 10 gives 11 idle cycles plus a 37-cycle sweep
      load_board(0, rand_board());
      period = PERIOD_W'(10);
      @(negedge clk);
      s = cyc;
      run_r[0] = 1'b1;
      for (int j = 0; j < 3; j++) begin
         exp_t e;
         n = life_step(mb[0], 1'b0);
         gen_m[0]++;
         e.inst = 0; e.gen = gen_m[0]; e.pop = popc(n); e.board = n;
         e.start = s + 10 + 48 * j; e.spaced = (j > 0);
         exp_q.push_back(e);
         mb[0] = n;
      end
      while (cyc < s + 25) @(negedge clk);
      next_r[0] = 1'b1;
      @(negedge clk);
      next_r[0] = 1'b0;
      drain();
      @(negedge clk);
      run_r[0] = 1'b0;
      repeat (60) @(negedge clk);
      chk("run_gen", 64'(gen[0]), 64'(gen_m[0]));

      // Reset during the write of row 7
      b0 = rand_board();
      load_board(0, b0);
      n = life_step(b0, 1'b0);
      step(0, s);
      while (cyc < s + 20) @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      chk("midrst_we", 64'(we[0]), 64'd0);
      chk("midrst_busy", 64'(busy[0]), 64'd0);
      chk("midrst_gen", 64'(gen[0]), 64'd0);
      rst = 1'b0;
      exp_q.delete();
      widx = 0;
      gen_m[0] = 0;
      gen_m[1] = 0;
      for (int r = 0; r < ROWS; r++) mb[0][r] = (r <= 7) ? n[r] : b0[r];
      repeat (5) @(negedge clk);
      chk_board("midrst_partial", ram_board(0), mb[0]);
      step_wait(0);
      chk("midrst_restep_gen", 64'(gen[0]), 64'd1);

      repeat (5) @(negedge clk);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
